// File: rtl/fpu_ex_seq.sv
// fpu_ex_seq: EX-stage FP sequencer timing per-opcode latency and driving stall/writeback strobes
module fpu_ex_seq #(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MADD = 4,
    parameter int unsigned LAT_CVT  = 2,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic        in_ready,
    output logic        ex_stall,
    output logic        ex_fpu_almost_done,
    output logic [31:0] ex_fp_inst,
    output logic [31:0] mem_fp_inst,
    output logic        fpu_start,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_to_int
);
    localparam logic [6:0] OPC_FP      = 7'b1010011;
    localparam logic [6:0] OPC_FP_MADD = 7'b1000011;

    logic        busy_q, busy_d, first_q, first_d;
    logic [2:0]  cnt_q, cnt_d, lat;
    logic [31:0] ex_q, ex_d, mem_q, mem_d;
    logic        is_fp, accept;

    assign in_ready           = !busy_q || cnt_q == 3'd1;
    assign ex_stall           = busy_q && cnt_q >= 3'd2;
    assign ex_fpu_almost_done = busy_q && cnt_q == 3'd2;
    assign wb_valid           = busy_q && cnt_q == 3'd1;
    assign fpu_start          = busy_q && first_q;
    assign ex_fp_inst         = ex_q;
    assign mem_fp_inst        = mem_q;
    assign wb_rd              = ex_q[11:7];
    assign wb_to_int          = ex_q[6:0] == OPC_FP && ex_q[31:28] == 4'b1110;

    // Decode the incoming op and its EX latency; flush kills any same-cycle accept
    always_comb begin
        is_fp  = in_inst[6:0] == OPC_FP || in_inst[6:0] == OPC_FP_MADD;
        lat    = in_inst[6:0] == OPC_FP_MADD   ? 3'(LAT_MADD) :
                 in_inst[31:28] == 4'b0000     ? 3'(LAT_ADD)  :
                 in_inst[31:28] == 4'b1101     ? 3'(LAT_CVT)  : 3'(LAT_MISC);
        accept = in_valid && is_fp && in_ready && !flush;
    end

    // Next state: count down while busy, retire at cnt==1, reload on accept, flush overrides all
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        first_d = 1'b0;
        mem_d   = wb_valid ? ex_q : '0;
        if (busy_q) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                busy_d = 1'b0;
                ex_d   = '0;
            end
        end
        if (accept) begin
            busy_d  = 1'b1;
            cnt_d   = lat;
            ex_d    = in_inst;
            first_d = 1'b1;
        end
        if (flush) begin
            busy_d  = 1'b0;
            ex_d    = '0;
            first_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_fpu_ex_seq.sv
// tb_fpu_ex_seq: scoreboard bench for fpu_ex_seq against an op-lifetime reference model
module tb_fpu_ex_seq;
    logic        clk = 0, rst = 0, in_valid = 0, flush = 0;
    logic [31:0] in_inst = 0;
    logic        in_ready, ex_stall, ex_fpu_almost_done, fpu_start, wb_valid, wb_to_int;
    logic [31:0] ex_fp_inst, mem_fp_inst;
    logic [4:0]  wb_rd;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct {
        logic [31:0] inst;
        int          due;
    } exp_t;
    exp_t sbq[$];

    // Reference model: the op in EX, the cycle it was presented and its latency
    bit          m_busy = 0, m_done, m_acc_now;
    int          m_acc = 0, m_lat = 1, mk;
    logic [31:0] m_inst = 0, m_mem = 0;
    exp_t        e;

    localparam logic [31:0] FADD  = 32'h00208053;
    localparam logic [31:0] FADD5 = 32'h002082D3;
    localparam logic [31:0] FMADD = 32'h002081C3;
    localparam logic [31:0] FSGNJ = 32'h20000053;
    localparam logic [31:0] FMVXW = 32'hE00003D3;

    fpu_ex_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .flush(flush),
        .in_ready(in_ready), .ex_stall(ex_stall), .ex_fpu_almost_done(ex_fpu_almost_done),
        .ex_fp_inst(ex_fp_inst), .mem_fp_inst(mem_fp_inst), .fpu_start(fpu_start),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_to_int(wb_to_int)
    );

    always #5 clk = ~clk;

    function automatic bit is_fp(logic [31:0] i);
        return i[6:0] == 7'b1010011 || i[6:0] == 7'b1000011;
    endfunction

    function automatic int lat_of(logic [31:0] i);
        if (i[6:0] == 7'b1000011) return 4;
        if (i[31:28] == 4'b0000) return 3;
        if (i[31:28] == 4'b1101) return 2;
        return 1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Model update at each edge: retire, flush, accept (pushes the expected writeback)
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0;
            m_inst = 0;
            m_mem  = 0;
            sbq.delete();
        end else begin
            m_done    = m_busy && (cyc - m_acc == m_lat);
            m_acc_now = in_valid && is_fp(in_inst) && (!m_busy || m_done) && !flush;
            m_mem     = m_done ? m_inst : 0;
            if (m_done || flush) begin
                m_busy = 0;
                m_inst = 0;
            end
            if (flush) sbq.delete();
            if (m_acc_now) begin
                m_busy = 1;
                m_acc  = cyc;
                m_lat  = lat_of(in_inst);
                m_inst = in_inst;
                sbq.push_back('{in_inst, cyc + m_lat});
            end
            cyc++;
        end
    end

    // Monitor: per-cycle strobes against the model, writebacks against the scoreboard
    always @(negedge clk) begin
        mk = cyc - m_acc;
        chk("in_ready", 32'(in_ready), 32'(!m_busy || mk == m_lat));
        chk("ex_stall", 32'(ex_stall), 32'(m_busy && mk < m_lat));
        chk("almost_done", 32'(ex_fpu_almost_done), 32'(m_busy && mk == m_lat - 1));
        chk("fpu_start", 32'(fpu_start), 32'(m_busy && mk == 1));
        chk("ex_fp_inst", ex_fp_inst, m_busy ? m_inst : 0);
        chk("mem_fp_inst", mem_fp_inst, m_mem);
        if (wb_valid) begin
            if (sbq.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 0);
            end else begin
                e = sbq.pop_front();
                chk("wb_cycle", cyc, e.due);
                chk("wb_rd", 32'(wb_rd), 32'(e.inst[11:7]));
                chk("wb_to_int", 32'(wb_to_int), 32'(e.inst[6:0] == 7'b1010011 && e.inst[31:28] == 4'b1110));
                chk("wb_inst", ex_fp_inst, e.inst);
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("wb_missing", 32'(wb_valid), 1);
        end
    end

    task automatic drive(bit v, logic [31:0] inst, bit f);
        @(posedge clk);
        #1;
        in_valid = v;
        in_inst  = inst;
        flush    = f;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        drive(1, FADD, 0);
        idle(6);
        drive(1, FMADD, 0);
        repeat (4) drive(1, FADD5, 0);
        idle(6);
        for (int i = 1; i <= 4; i++) drive(1, FSGNJ | (i << 7), 0);
        idle(3);
        drive(1, FMVXW, 0);
        idle(3);
        drive(1, FMADD, 0);
        drive(0, 0, 0);
        drive(0, 0, 1);
        idle(4);
        drive(1, FADD, 0);
        drive(0, 0, 0);
        @(posedge clk);
        #3 rst = 0;
        #1;
        chk("rst_async_ready", 32'(in_ready), 1);
        chk("rst_async_wb", 32'(wb_valid), 0);
        chk("rst_async_ex", ex_fp_inst, 0);
        chk("rst_async_stall", 32'(ex_stall), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        drive(1, FADD, 0);
        idle(6);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            case ($urandom_range(0, 6))
                0: r[31:28] = 4'h0;
                1: r[31:28] = 4'hD;
                2: r[31:28] = 4'h2;
                3: r[31:28] = 4'hE;
                4: r[31:28] = 4'hF;
                default: ;
            endcase
            case ($urandom_range(0, 4))
                0: r[6:0] = 7'h43;
                1: r[6:0] = 7'h33;
                default: r[6:0] = 7'h53;
            endcase
            drive($urandom_range(0, 3) != 0, r, $urandom_range(0, 19) == 0);
        end
        idle(10);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_ex_seq.md
Name: fpu_ex_seq

Overview:
- EX-stage floating-point sequencer. It is the producer side of the FP hazard/stall signals that the ID control logic consumes.
- Accepts one FP instruction at a time from ID and times its multi-cycle latency by opcode.
- Drives ex_stall, ex_fpu_almost_done, ex_fp_inst and mem_fp_inst back to ID.
- Issues start/writeback strobes to the FP datapath and the register-file write port.

Parameters:
- LAT_ADD, 3, cycles in EX for FADD (funct4 0000); legal range 1..7
- LAT_MADD, 4, cycles in EX for FMADD (opcode 1000011); legal range 1..7
- LAT_CVT, 2, cycles in EX for FCVT.S.W (funct4 1101); legal range 1..7
- LAT_MISC, 1, cycles in EX for FSGNJ (0010), FMV.X.W (1110), FMV.W.X (1111) and any other funct4 under OPC_FP; legal range 1..7

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  ID presents an instruction to EX this cycle (not stalled)
- in_inst  in  32  instruction from ID
- flush  in  1  kill any in-flight FP op (redirect)
- in_ready  out  1  sequencer can accept an FP op this cycle
- ex_stall  out  1  FP op in EX needs more cycles
- ex_fpu_almost_done  out  1  FP op completes next cycle
- ex_fp_inst  out  32  FP instruction currently in EX; 0 when none
- mem_fp_inst  out  32  FP instruction that completed last cycle; 0 otherwise
- fpu_start  out  1  first EX cycle of an op (datapath latches operands)
- wb_valid  out  1  result valid this cycle
- wb_rd  out  5  destination, equal to ex_fp_inst[11:7]
- wb_to_int  out  1  destination is the integer file (FMV.X.W); else FP file

Behaviour:
- FP op: in_inst[6:0] == 1010011 (OPC_FP) or 1000011 (OPC_FP_MADD). Non-FP instructions are ignored.
- Accept: in_valid && FP op && in_ready && !flush.
- On accept (clock edge):
  - busy <= 1
  - cnt <= LAT for that op
  - ex_fp_inst <= in_inst
  - first <= 1
- State: busy flag plus 3-bit down-counter cnt. While busy, cnt decrements by 1 each cycle.
- in_ready = !busy || cnt == 1. Back-to-back issue is allowed in the completion cycle.
- ex_stall = busy && cnt >= 2.
- ex_fpu_almost_done = busy && cnt == 2. Never asserted for LAT == 1.
- wb_valid = busy && cnt == 1. wb_rd and wb_to_int are decoded from ex_fp_inst.
- fpu_start = busy && first. first clears after one cycle.
- Cycle sequence with LAT = L, accept at edge 0:
  - cycle 1: cnt = L, fpu_start = 1
  - cycles 1 .. L-1: ex_stall = 1
  - cycle L-1: ex_fpu_almost_done = 1
  - cycle L: wb_valid = 1
- Completion edge without a new accept: busy <= 0, ex_fp_inst <= 0.
- Completion edge with a simultaneous accept: the new op loads. The old op still writes back in the completion cycle.
- mem_fp_inst <= wb_valid ? ex_fp_inst : 0, every edge (single-cycle pipeline copy).
- in_valid with an FP op while !in_ready: ignored, no state change. ID is responsible for holding the instruction.
- flush (synchronous, highest priority):
  - busy <= 0, ex_fp_inst <= 0, first <= 0
  - same-cycle accept is dropped
  - wb_valid is still driven combinationally in that cycle if cnt == 1
  - mem_fp_inst follows its normal rule
- Reset (asserted asynchronously, any time, including mid-op): all state cleared. All outputs read 0 except in_ready, which reads 1. No wb_valid after reset.
- Counter never wraps: cnt is only reloaded on accept and stops once busy is 0.

Test Plan:
- FADD (in_inst 0x00208053) accepted at cycle 0 → fpu_start at cycle 1; ex_stall at cycles 1–2; ex_fpu_almost_done at cycle 2; wb_valid at cycle 3 with wb_rd = 0, wb_to_int = 0; mem_fp_inst = 0x00208053 at cycle 4, then 0.
- FMADD then FADD: FADD held at in_valid from cycle 1 → in_ready = 0 for cycles 1–3; accepted at cycle 4 (completion cycle, in_ready = 1); FMADD wb_valid at cycle 4; FADD fpu_start at cycle 5; no idle cycle in between.
- FSGNJ ops issued every cycle for 4 cycles → ex_stall and ex_fpu_almost_done never asserted; wb_valid high for 4 consecutive cycles with correct wb_rd each cycle.
- FMV.X.W with rd = 7 → wb_to_int = 1 and wb_rd = 7 in the single EX cycle.
- FMADD accepted, flush at cycle 2 → busy clears; ex_fp_inst = 0 at cycle 3; no wb_valid; in_ready = 1 at cycle 3.
- rst driven low asynchronously mid-FADD (cycle 2), released at cycle 4 → all outputs 0 except in_ready = 1; no wb_valid from the aborted op; a new FADD after release completes with normal latency.
